// File: rtl/store_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_write_buffer_pkg
// Shared definitions for the store write buffer, the LSU and the memory-model
// wrapper: address/data/mask widths and the packed store entry type.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package store_write_buffer_pkg;

   localparam int AW = 32;        // address width
   localparam int DW = 32;        // data width
   localparam int MW = DW / 8;    // byte-mask width

   // Field order matters: addr occupies the most significant bits.
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
   } store_entry_t;

   localparam int EW = $bits(store_entry_t);

endpackage

// File: rtl/store_write_buffer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// In-order circular FIFO with per-entry valid bits. The head entry is read
// combinationally so it can be presented the cycle after it was written.
// All entries and their valid bits are exported so the owner can search the
// pending contents (e.g. for address hazards).
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (pointers, count, valid bits)
//   push     in   write wdata at tail (ignored when full)
//   wdata    in   entry to enqueue
//   pop      in   retire the head entry (ignored when empty)
//   rdata    out  head entry
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  number of stored entries, 0..DEPTH
//   entries  out  all storage slots, slot i at [i*W +: W]
//   valid    out  per-slot occupancy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DEPTH*W-1:0]         entries,
   output logic [DEPTH-1:0]           valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]    mem_reg [DEPTH];
   logic [PW-1:0]   head_reg;
   logic [PW-1:0]   tail_reg;
   logic [CW-1:0]   count_reg;
   logic [DEPTH-1:0] valid_reg;
   logic            do_push;
   logic            do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign valid   = valid_reg;
   assign rdata   = mem_reg[head_reg];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (do_push) tail_reg <= tail_reg + PW'(1);
         if (do_pop)  head_reg <= head_reg + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Payload needs no reset; occupancy is tracked by valid_reg/count_reg.
   always_ff @(posedge clock) begin
      if (do_push) mem_reg[tail_reg] <= wdata;
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         assign entries[gi*W +: W] = mem_reg[gi];

         // Push and pop never target the same slot in one cycle: that would
         // need count==0 (pop blocked) or count==DEPTH (push blocked).
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               valid_reg[gi] <= 1'b0;
            end else if (do_push && (tail_reg == PW'(gi))) begin
               valid_reg[gi] <= 1'b1;
            end else if (do_pop && (head_reg == PW'(gi))) begin
               valid_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
// Buffers LSU stores in an in-order FIFO and drains them one per handshake to
// the data-memory write port. Flags loads whose word matches a pending store.
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset; discards pending stores
//   req_valid   in   LSU store request valid
//   req_ready   out  buffer can accept (not full; independent of mem_wready)
//   req_addr    in   store byte address
//   req_data    in   store data, already lane-shifted
//   req_mask    in   byte enables; an all-zero mask is accepted and dropped
//   mem_wvalid  out  head entry presented to memory
//   mem_wready  in   memory accepts the write this cycle
//   mem_waddr   out  head address (0 when idle)
//   mem_wdata   out  head data (0 when idle)
//   mem_wmask   out  head mask (0 when idle)
//   ld_addr     in   address of the load in the LSU
//   ld_hit      out  a pending store covers ld_addr's word
//   empty       out  no pending stores
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module store_write_buffer
   import store_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
   input  logic [MW-1:0] req_mask,
   output logic          mem_wvalid,
   input  logic          mem_wready,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic [MW-1:0] mem_wmask,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   output logic          empty
);

   localparam int CW = $clog2(DEPTH) + 1;

   store_entry_t        req_entry;
   store_entry_t        head_entry;
   logic [EW-1:0]       fifo_rdata;
   logic [DEPTH*EW-1:0] fifo_entries;
   logic [DEPTH-1:0]    fifo_valid;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CW-1:0]       fifo_count;
   logic                push;
   logic                pop;
   logic [DEPTH-1:0]    hit_vec;
   logic [DEPTH-1:0]    unused_payload;
   logic                unused_ld_lsb;

   assign req_entry = '{addr: req_addr, data: req_data, mask: req_mask};

   // Ready depends only on occupancy, so a full buffer refuses a request
   // even when the head drains in the same cycle.
   assign req_ready = !fifo_full;

   // Zero-mask stores complete the handshake but are never stored, which
   // also guarantees the memory port never sees an all-zero mask.
   assign push = req_valid && req_ready && (req_mask != '0);

   assign mem_wvalid = (fifo_count != '0);
   assign pop        = mem_wvalid && mem_wready;
   assign empty      = fifo_empty;

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (req_entry),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count),
      .entries (fifo_entries),
      .valid   (fifo_valid)
   );

   assign head_entry = fifo_rdata;

   // Head payload is unreset storage; hold the port at zero while idle.
   assign mem_waddr = mem_wvalid ? head_entry.addr : '0;
   assign mem_wdata = mem_wvalid ? head_entry.data : '0;
   assign mem_wmask = mem_wvalid ? head_entry.mask : '0;

   // Word-granular hazard search over every occupied slot, including the
   // head while it is being retired this cycle.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
         store_entry_t slot;
         assign slot = fifo_entries[gi*EW +: EW];
         assign hit_vec[gi] = fifo_valid[gi] &&
                              (slot.addr[AW-1:2] == ld_addr[AW-1:2]);
         assign unused_payload[gi] = ^{slot.data, slot.mask, slot.addr[1:0]};
      end
   endgenerate

   assign ld_hit        = |hit_vec;
   assign unused_ld_lsb = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_write_buffer.sv
`timescale 1ns/1ps
module tb_store_write_buffer;
   import store_write_buffer_pkg::*;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_data = '0;
   logic [MW-1:0] req_mask = '0;
   logic          mem_wvalid;
   logic          mem_wready = 1'b0;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic [AW-1:0] ld_addr = '0;
   logic          ld_hit;
   logic          empty;

   int checks = 0;
   int failures = 0;

   store_write_buffer #(.DEPTH(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_mask   (req_mask),
      .mem_wvalid (mem_wvalid),
      .mem_wready (mem_wready),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .ld_addr    (ld_addr),
      .ld_hit     (ld_hit),
      .empty      (empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are then settled and stable.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input logic v, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [MW-1:0] m);
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      req_mask  = m;
   endtask

   // One line per memory write transaction.
   always @(posedge clock) begin
      if (reset_n && mem_wvalid && mem_wready)
         $display("write addr=0x%08h data=0x%08h mask=0x%0h", mem_waddr, mem_wdata, mem_wmask);
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset state
      #12;
      check("rst_req_ready", 64'(req_ready), 64'(1));
      check("rst_wvalid",    64'(mem_wvalid), 64'(0));
      check("rst_waddr",     64'(mem_waddr), 64'(0));
      check("rst_wdata",     64'(mem_wdata), 64'(0));
      check("rst_wmask",     64'(mem_wmask), 64'(0));
      check("rst_ld_hit",    64'(ld_hit), 64'(0));
      check("rst_empty",     64'(empty), 64'(1));
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // ---------------- single store
      mem_wready = 1'b1;
      drive_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
      tick();
      drive_req(1'b0, '0, '0, '0);
      check("single_wvalid", 64'(mem_wvalid), 64'(1));
      check("single_waddr",  64'(mem_waddr), 64'h8000_0010);
      check("single_wdata",  64'(mem_wdata), 64'hDEAD_BEEF);
      check("single_wmask",  64'(mem_wmask), 64'hF);
      check("single_empty0", 64'(empty), 64'(0));
      tick();
      check("single_empty1", 64'(empty), 64'(1));
      check("single_idle",   64'(mem_wvalid), 64'(0));

      // ---------------- fill and backpressure
      mem_wready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_req(1'b1, 32'h8000_0000 + 32'(4*k), 32'h100 + 32'(k), 4'hF);
         #1;
         check($sformatf("fill_ready_%0d", k), 64'(req_ready), (k < 4) ? 64'(1) : 64'(0));
         tick();
      end
      drive_req(1'b0, '0, '0, '0);
      check("fill_wvalid", 64'(mem_wvalid), 64'(1));
      check("fill_empty",  64'(empty), 64'(0));
      mem_wready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("drain_waddr_%0d", k), 64'(mem_waddr), 64'h8000_0000 + 64'(4*k));
         check($sformatf("drain_wdata_%0d", k), 64'(mem_wdata), 64'h100 + 64'(k));
         check($sformatf("drain_ready_%0d", k), 64'(req_ready), (k == 0) ? 64'(0) : 64'(1));
         tick();
      end
      check("drain_empty",  64'(empty), 64'(1));
      check("drain_wvalid", 64'(mem_wvalid), 64'(0));

      // ---------------- streaming push/pop with wrap
      mem_wready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_req(1'b1, 32'h8000_0200 + 32'(4*i), 32'h200 + 32'(i), 4'hF);
         tick();
         check($sformatf("stream_wvalid_%0d", i), 64'(mem_wvalid), 64'(1));
         check($sformatf("stream_waddr_%0d", i),  64'(mem_waddr), 64'h8000_0200 + 64'(4*i));
         check($sformatf("stream_wdata_%0d", i),  64'(mem_wdata), 64'h200 + 64'(i));
         check($sformatf("stream_ready_%0d", i),  64'(req_ready), 64'(1));
      end
      drive_req(1'b0, '0, '0, '0);
      tick();
      check("stream_empty", 64'(empty), 64'(1));

      // ---------------- load hazard
      mem_wready = 1'b0;
      ld_addr = 32'h8000_0104;
      drive_req(1'b1, 32'h8000_0104, 32'h0000_AB00, 4'b0010);
      #1;
      check("haz_before_push", 64'(ld_hit), 64'(0));
      tick();
      drive_req(1'b0, '0, '0, '0);
      ld_addr = 32'h8000_0107;
      #1;
      check("haz_same_word", 64'(ld_hit), 64'(1));
      ld_addr = 32'h8000_0108;
      #1;
      check("haz_next_word", 64'(ld_hit), 64'(0));
      check("haz_wmask",     64'(mem_wmask), 64'h2);
      ld_addr = 32'h8000_0104;
      mem_wready = 1'b1;
      #1;
      check("haz_during_drain", 64'(ld_hit), 64'(1));
      tick();
      check("haz_after_drain", 64'(ld_hit), 64'(0));

      // ---------------- zero mask
      mem_wready = 1'b0;
      drive_req(1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0000);
      #1;
      check("zmask_ready", 64'(req_ready), 64'(1));
      tick();
      drive_req(1'b0, '0, '0, '0);
      check("zmask_empty",  64'(empty), 64'(1));
      check("zmask_wvalid", 64'(mem_wvalid), 64'(0));
      tick();
      check("zmask_wvalid2", 64'(mem_wvalid), 64'(0));

      // ---------------- reset mid-drain
      mem_wready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b1, 32'h8000_0300 + 32'(4*i), 32'h300 + 32'(i), 4'hF);
         tick();
      end
      drive_req(1'b0, '0, '0, '0);
      check("rmid_wvalid_pre", 64'(mem_wvalid), 64'(1));
      check("rmid_waddr_pre",  64'(mem_waddr), 64'h8000_0300);
      #2;
      reset_n = 1'b0;
      #1;
      check("rmid_wvalid", 64'(mem_wvalid), 64'(0));
      check("rmid_empty",  64'(empty), 64'(1));
      check("rmid_waddr",  64'(mem_waddr), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;
      mem_wready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rmid_post_wvalid_%0d", i), 64'(mem_wvalid), 64'(0));
      end
      check("rmid_post_empty", 64'(empty), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Write-side counterpart to the instruction-fetch read path.
- Accepts store requests from the LSU (address, data, byte mask) over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains entries one per handshake to the data-memory write port (mem_w*), which the simulation memory model services.
- Gives the load path a conflict flag so loads never read stale memory behind a pending store.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- AW, 32, address width.
- DW, 32, data width; mask width is DW/8.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSU store request valid.
- req_ready  out  1  buffer can accept a request.
- req_addr  in  AW  store byte address; word-aligned part used for hazard compare.
- req_data  in  DW  store data, already lane-shifted.
- req_mask  in  DW/8  byte write enables.
- mem_wvalid  out  1  head entry presented to memory.
- mem_wready  in  1  memory accepts the write this cycle.
- mem_waddr  out  AW  head address.
- mem_wdata  out  DW  head data.
- mem_wmask  out  DW/8  head mask.
- ld_addr  in  AW  address of the load currently in the LSU.
- ld_hit  out  1  a pending store overlaps ld_addr's word.
- empty  out  1  no pending stores; used by fence/ebreak drain.

Behaviour:
- **Storage:** circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH. The count register is log2(DEPTH)+1 bits, range 0..DEPTH.
- **Reset:** async on reset_n low. Clears count, head, tail and all entry valid bits; pending stores are discarded.
  - Reset values: req_ready=1, mem_wvalid=0, mem_waddr/wdata/wmask=0, ld_hit=0, empty=1.
  - Entry payload registers need no reset.
- **Enqueue:** on req_valid && req_ready at a rising edge, the entry is written at tail and tail advances.
  - req_ready = (count != DEPTH). It is registered-equivalent (no combinational path from mem_wready), so a full buffer does not accept even when a dequeue happens in the same cycle.
  - req_mask == 0: the handshake completes (ready as above) but nothing is enqueued and tail does not move.
- **Dequeue:**
  - mem_wvalid = (count != 0). mem_waddr/wdata/wmask are driven from the head entry.
  - Once mem_wvalid is high, it and the payload stay stable until mem_wready; the head advances at that edge.
  - Write latency: a store accepted at edge N is presented on mem_w* from cycle N+1 at the earliest, when the buffer was empty.
- **Simultaneous enqueue and dequeue:** count unchanged, both pointers advance. This is legal at any count from 1 to DEPTH-1.
- **Wrap-around:** pointers wrap from DEPTH-1 to 0 with no bubble.
- **ld_hit** (combinational): OR over valid entries of (entry.addr[AW-1:2] == ld_addr[AW-1:2]).
  - Entries dequeuing this cycle still count.
  - An entry enqueued at this edge counts from the next cycle.
  - The LSU stalls the load while ld_hit is high; there is no forwarding.
- **empty** = (count == 0).
- **Ordering:** strictly FIFO; no coalescing or merging of stores.
- **Memory port:** never issues a write with mem_wmask == 0.

Decomposition:
- Shared package holds:
  - the constants AW, DW, MW = DW/8;
  - the typedef store_entry_t {addr[AW], data[DW], mask[MW]}, reused by the LSU and the memory-model wrapper.
- One natural sub-module: sync_fifo (parameterised over DEPTH and entry width, with full/empty/count). The top level adds the zero-mask filter, the hazard compare array and the port mapping.

Test Plan:
- **Single store:** after reset, send store addr=0x80000010, data=0xDEADBEEF, mask=4'b1111 with mem_wready=1. Required: mem_wvalid rises the next cycle carrying the same values; empty returns to 1 after that handshake.
- **Fill and backpressure:** mem_wready=0, send 5 stores to 0x80000000+4k. Required: the first 4 are accepted; req_ready=0 on the 5th. Then raise mem_wready: writes emerge in order k=0..3; req_ready returns after the first drain.
- **Simultaneous push/pop with wrap:** stream 10 stores while mem_wready=1 continuously. Required: count stays ≤1, pointers wrap past DEPTH-1, and all 10 writes appear in order with no bubble.
- **Load hazard:** pending store to 0x80000104 with mask 4'b0010 and mem_wready=0. Required: ld_addr=0x80000107 gives ld_hit=1; ld_addr=0x80000108 gives ld_hit=0; after the drain handshake, ld_hit=0.
- **Zero mask:** send mask=0 to 0x1000. Required: handshake completes, empty stays 1, mem_wvalid stays 0.
- **Reset mid-drain:** with 3 entries pending and mem_wvalid=1, assert reset_n=0 asynchronously between edges. Required: mem_wvalid=0 and empty=1 immediately; no stale writes appear after release.
